// File: rtl/proc_instr_feeder.sv
// proc_instr_feeder: program memory plus sequencer that feeds the 16-bit proc
// core over its DIN/Run/Done handshake. Each instruction gets a one-cycle Run
// pulse. The instruction then completes on Done or after TIMEOUT wait cycles,
// whichever comes first, and the sequencer moves on to the next one.
module proc_instr_feeder #(
  parameter int AW      = 4,
  parameter int TIMEOUT = 3,
  parameter int CW      = 8
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          WrEn,
  input  logic [AW-1:0] WrAddr,
  input  logic [15:0]   WrData,
  input  logic          Start,
  input  logic [AW:0]   Len,
  input  logic          Stop,
  input  logic          Done,
  output logic [15:0]   DOUT,
  output logic          Run,
  output logic          Busy,
  output logic [AW-1:0] PC,
  output logic          Finished,
  output logic [CW-1:0] TimeoutCnt
);

  localparam int DEPTH = 1 << AW;
  // Wait counter only needs to reach TIMEOUT-1.
  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WAIT_ONE  = WW'(1);
  localparam logic [AW-1:0] PC_ONE    = AW'(1);
  localparam logic [AW:0]   REM_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   LEN_ZERO  = (AW + 1)'(0);
  localparam logic [CW-1:0] TCNT_ONE  = CW'(1);
  localparam logic [CW-1:0] TCNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     mem_q [DEPTH];
  logic [AW-1:0]   pc_q, pc_d;
  logic [AW:0]     rem_q, rem_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [CW-1:0]   tcnt_q, tcnt_d;
  logic            stop_q, stop_d;
  logic [15:0]     dout_q, dout_d;
  logic            run_q, run_d;
  logic            busy_q, busy_d;
  logic            fin_q, fin_d;

  logic            in_wait_s;
  logic            wait_expired_s;
  logic            complete_s;
  logic            timeout_ev_s;
  logic            stop_pend_s;
  logic            last_s;

  // Completion conditions in WAIT; Done takes priority over the timeout.
  always_comb begin
    in_wait_s      = (state_q == S_WAIT);
    wait_expired_s = (wcnt_q == WAIT_LAST);
    complete_s     = in_wait_s && (Done || wait_expired_s);
    timeout_ev_s   = in_wait_s && !Done && wait_expired_s;
    stop_pend_s    = stop_q || Stop;
    last_s         = (rem_q == REM_ONE);
  end

  // Program memory write port, locked out while a program is running.
  always_ff @(posedge Clock) begin
    if (WrEn && !busy_q) begin
      mem_q[WrAddr] <= WrData;
    end
  end

  // FSM state register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = (Len == LEN_ZERO) ? S_FIN : S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (complete_s) begin
          state_d = (last_s || stop_pend_s) ? S_FIN : S_ISSUE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer datapath: PC, remaining count, wait timer, timeout tally, stop flag.
  always_comb begin
    pc_d   = pc_q;
    rem_d  = rem_q;
    wcnt_d = wcnt_q;
    tcnt_d = tcnt_q;
    stop_d = stop_q;
    case (state_q)
      S_IDLE: begin
        if (Start && (Len != LEN_ZERO)) begin
          pc_d   = '0;
          rem_d  = Len;
          tcnt_d = '0;
        end else begin
          pc_d   = pc_q;
          rem_d  = rem_q;
          tcnt_d = tcnt_q;
        end
      end
      S_ISSUE: begin
        wcnt_d = '0;
        if (Stop) begin
          stop_d = 1'b1;
        end else begin
          stop_d = stop_q;
        end
      end
      S_WAIT: begin
        if (Stop) begin
          stop_d = 1'b1;
        end else begin
          stop_d = stop_q;
        end
        if (complete_s) begin
          pc_d   = pc_q + PC_ONE;
          rem_d  = rem_q - REM_ONE;
          wcnt_d = '0;
        end else begin
          wcnt_d = wcnt_q + WAIT_ONE;
        end
        if (timeout_ev_s && (tcnt_q != TCNT_MAX)) begin
          tcnt_d = tcnt_q + TCNT_ONE;
        end else begin
          tcnt_d = tcnt_q;
        end
      end
      S_FIN: begin
        stop_d = 1'b0;
      end
      default: begin
        stop_d = 1'b0;
      end
    endcase
  end

  // FSM output decode, computed from the next state so outputs can be registered.
  always_comb begin
    run_d  = (state_d == S_ISSUE);
    busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
    fin_d  = (state_d == S_FIN);
    if (state_d == S_ISSUE) begin
      dout_d = mem_q[pc_d];
    end else begin
      dout_d = dout_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pc_q   <= '0;
      rem_q  <= '0;
      wcnt_q <= '0;
      tcnt_q <= '0;
      stop_q <= 1'b0;
      dout_q <= 16'h0000;
      run_q  <= 1'b0;
      busy_q <= 1'b0;
      fin_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      rem_q  <= rem_d;
      wcnt_q <= wcnt_d;
      tcnt_q <= tcnt_d;
      stop_q <= stop_d;
      dout_q <= dout_d;
      run_q  <= run_d;
      busy_q <= busy_d;
      fin_q  <= fin_d;
    end
  end

  assign DOUT       = dout_q;
  assign Run        = run_q;
  assign Busy       = busy_q;
  assign PC         = pc_q;
  assign Finished   = fin_q;
  assign TimeoutCnt = tcnt_q;

endmodule

// File: tb/tb_proc_instr_feeder.sv
// Bench for proc_instr_feeder. A small proc-like responder answers Run with
// Done at the right cycle for each opcode class. A table of runs gives the
// expected busy length, Finished latency, PC and timeout count. Expected DOUT
// words go into a queue when each run starts and are popped on every Run pulse.
module tb_proc_instr_feeder;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        WrEn = 1'b0;
  logic [3:0]  WrAddr = 4'd0;
  logic [15:0] WrData = 16'h0000;
  logic        Start = 1'b0;
  logic [4:0]  Len = 5'd0;
  logic        Stop = 1'b0;
  logic        Done;
  logic [15:0] DOUT;
  logic        Run;
  logic        Busy;
  logic [3:0]  PC;
  logic        Finished;
  logic [7:0]  TimeoutCnt;

  proc_instr_feeder #(.AW(4), .TIMEOUT(3), .CW(8)) dut (
    .Clock(Clock), .Resetn(Resetn), .WrEn(WrEn), .WrAddr(WrAddr),
    .WrData(WrData), .Start(Start), .Len(Len), .Stop(Stop), .Done(Done),
    .DOUT(DOUT), .Run(Run), .Busy(Busy), .PC(PC), .Finished(Finished),
    .TimeoutCnt(TimeoutCnt)
  );

  always #5 Clock = ~Clock;

  // Responder: mv/mvt finish in T1, add/sub in T3, opcodes 1xx never finish.
  int         rsp_t;
  logic [2:0] rsp_op;
  logic       rsp_en = 1'b1;
  logic       done_force = 1'b0;
  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rsp_t  <= 0;
      rsp_op <= 3'd0;
    end else if (Run) begin
      rsp_t  <= 1;
      rsp_op <= DOUT[15:13];
    end else if (rsp_t != 0) begin
      rsp_t <= (rsp_t == 3) ? 0 : rsp_t + 1;
    end
  end
  assign Done = rsp_en ? (((rsp_t == 1) && (rsp_op[2:1] == 2'b00)) ||
                          ((rsp_t == 3) && (rsp_op[2:1] == 2'b01)))
                       : done_force;

  int n_checks = 0;
  int n_err = 0;
  logic [15:0] shadow [16];
  logic [15:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    @(negedge Clock);
    WrEn = 1'b1; WrAddr = a; WrData = d;
    @(negedge Clock);
    WrEn = 1'b0;
    shadow[a] = d;
  endtask

  // done_at: -1 uses the responder, 0 never raises Done, k>0 raises Done in cycle k only.
  typedef struct {
    logic [4:0] len;
    int         stop_at;
    int         done_at;
    bit         wr_busy;
    int         runs;
    int         busy;
    logic [7:0] tcnt;
    logic [3:0] pc;
  } vec_t;

  vec_t vecs[11];

  task automatic run_vec(input int id, input vec_t v);
    int idx;
    int busy_n;
    int fin_idx;
    string tag;
    tag = $sformatf("v%0d", id);
    for (int i = 0; i < v.runs; i++) exp_q.push_back(shadow[i % 16]);
    @(negedge Clock);
    rsp_en = (v.done_at < 0);
    Start = 1'b1;
    Len = v.len;
    idx = 0; busy_n = 0; fin_idx = 0;
    while (fin_idx == 0 && idx < 200) begin
      @(negedge Clock);
      idx++;
      Start = 1'b0; Stop = 1'b0; WrEn = 1'b0; done_force = 1'b0;
      if (Busy) busy_n++;
      if (Run) begin
        if (exp_q.size() == 0) chk({tag, "_unexpected_run"}, 32'd1, 32'd0);
        else chk({tag, "_dout"}, {16'h0, DOUT}, {16'h0, exp_q.pop_front()});
      end
      if (Finished) fin_idx = idx;
      if (idx == v.stop_at) Stop = 1'b1;
      if (idx == v.done_at) done_force = 1'b1;
      if (v.wr_busy && idx == 2) begin
        WrEn = 1'b1; WrAddr = 4'd1; WrData = 16'hFFFF;
      end
    end
    @(negedge Clock);
    Stop = 1'b0; WrEn = 1'b0; done_force = 1'b0;
    chk({tag, "_fin_latency"}, fin_idx, v.busy + 1);
    chk({tag, "_busy_cycles"}, busy_n, v.busy);
    chk({tag, "_runs_left"}, exp_q.size(), 32'd0);
    exp_q.delete();
    chk({tag, "_fin_pulse"}, {31'd0, Finished}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, Busy}, 32'd0);
    chk({tag, "_pc"}, {28'd0, PC}, {28'd0, v.pc});
    chk({tag, "_tcnt"}, {24'd0, TimeoutCnt}, {24'd0, v.tcnt});
    rsp_en = 1'b1;
  endtask

  initial begin
    // Program: mv, add, unsupported, mvt, then mv fillers. Costs 2,4,4,2,2...
    vecs[0]  = '{5'd2,  0, -1, 1'b0,  2,  6, 8'd0, 4'd2};
    vecs[1]  = '{5'd4,  0, -1, 1'b0,  4, 12, 8'd1, 4'd4};
    vecs[2]  = '{5'd0,  0, -1, 1'b0,  0,  0, 8'd1, 4'd4};
    vecs[3]  = '{5'd16, 0, -1, 1'b0, 16, 36, 8'd1, 4'd0};
    vecs[4]  = '{5'd4,  4, -1, 1'b1,  2,  6, 8'd0, 4'd2};
    vecs[5]  = '{5'd2,  0, -1, 1'b0,  2,  6, 8'd0, 4'd2};
    vecs[6]  = '{5'd4,  1, -1, 1'b0,  1,  2, 8'd0, 4'd1};
    vecs[7]  = '{5'd1,  0,  0, 1'b0,  1,  4, 8'd1, 4'd1};
    vecs[8]  = '{5'd1,  0,  4, 1'b0,  1,  4, 8'd0, 4'd1};
    vecs[9]  = '{5'd1,  0,  1, 1'b0,  1,  4, 8'd1, 4'd1};
    vecs[10] = '{5'd1,  0,  3, 1'b0,  1,  3, 8'd0, 4'd1};

    repeat (2) @(negedge Clock);
    chk("rst_dout", {16'h0, DOUT}, 32'd0);
    chk("rst_run", {31'd0, Run}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_pc", {28'd0, PC}, 32'd0);
    chk("rst_fin", {31'd0, Finished}, 32'd0);
    chk("rst_tcnt", {24'd0, TimeoutCnt}, 32'd0);
    Resetn = 1'b1;

    wr(4'd0, 16'h1005);
    wr(4'd1, 16'h5003);
    wr(4'd2, 16'h8000);
    wr(4'd3, 16'h2012);
    for (int i = 4; i < 16; i++) wr(i[3:0], 16'h1000 | 16'(i));

    for (int k = 0; k < 11; k++) run_vec(k, vecs[k]);

    // Asynchronous reset during WAIT of the third instruction.
    @(negedge Clock);
    Start = 1'b1; Len = 5'd3;
    for (int i = 1; i <= 8; i++) begin
      @(negedge Clock);
      Start = 1'b0;
    end
    chk("pre_rst_busy", {31'd0, Busy}, 32'd1);
    chk("pre_rst_dout", {16'h0, DOUT}, 32'h8000);
    #2 Resetn = 1'b0;
    #1;
    chk("arst_dout", {16'h0, DOUT}, 32'd0);
    chk("arst_busy", {31'd0, Busy}, 32'd0);
    chk("arst_pc", {28'd0, PC}, 32'd0);
    chk("arst_run", {31'd0, Run}, 32'd0);
    @(negedge Clock);
    Resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk("arst_no_fin", {31'd0, Finished}, 32'd0);
    end
    run_vec(11, vecs[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
